// File: rtl/fp_to_fixed_stream.sv
// Streaming IEEE-754 single to saturated signed Q(31-FRAC_BITS).FRAC_BITS converter.
// Optional round-half-away-from-zero when FP2FIX_ROUND_EN is defined; default truncates.
module fp_to_fixed_stream #(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [1:0]  m_axis_tuser
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StFix   = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  localparam logic signed [9:0] FracS = 10'(FRAC_BITS);

  logic [1:0]  r_state;
  logic [31:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_left;
  logic        r_sign;
  logic        r_nan;
  logic        r_ovf;
  logic [31:0] r_tdata;
  logic [1:0]  r_tuser;
  logic        r_tvalid;

  logic              w_sign;
  logic [7:0]        w_exp;
  logic [22:0]       w_frac;
  logic signed [9:0] w_s;
  logic              w_nan;
  logic              w_zero;
  logic              w_big;
  logic              w_tiny;
  logic              w_special;
  logic [5:0]        w_cnt;
  logic              w_hs;

  assign w_sign = s_axis_tdata[31];
  assign w_exp  = s_axis_tdata[30:23];
  assign w_frac = s_axis_tdata[22:0];

  // s = (exp - 127) - 23 + FRAC_BITS
  assign w_s    = $signed({2'b00, w_exp}) - 10'sd150 + FracS;
  assign w_nan  = (&w_exp) & (|w_frac);
  assign w_zero = ~|w_exp;
  // exp=255 always yields s >= 8, so infinities land in w_big too
  assign w_big  = w_s >= 10'sd8;
  assign w_tiny = w_s <= -10'sd25;
  assign w_special = w_nan | w_big | w_zero | w_tiny;
  assign w_cnt  = w_s[9] ? 6'(-w_s) : 6'(w_s);

  assign s_axis_tready = rst_n && (r_state == StIdle);
  assign w_hs          = s_axis_tvalid & s_axis_tready;

  logic [32:0] w_mag;
  logic        w_sat;
  logic [31:0] w_fix_data;
  logic [1:0]  w_fix_user;

`ifdef FP2FIX_ROUND_EN
  logic r_guard;

  // Guard holds the last bit dropped by a right shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_guard <= 1'b0;
    end else if (r_state == StIdle) begin
      r_guard <= 1'b0;
    end else if (r_state == StShift && !r_left) begin
      r_guard <= r_acc[0];
    end
  end

  assign w_mag = {1'b0, r_acc} + {32'd0, r_guard};
`else
  assign w_mag = {1'b0, r_acc};
`endif

  assign w_sat = r_ovf | (|w_mag[32:31]);

  always_comb begin
    w_fix_data = 32'd0;
    w_fix_user = 2'b00;
    if (r_nan) begin
      w_fix_user = 2'b10;
    end else if (w_sat) begin
      w_fix_data = r_sign ? 32'h8000_0000 : 32'h7fff_ffff;
      w_fix_user = 2'b01;
    end else begin
      w_fix_data = r_sign ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_acc    <= 32'd0;
      r_cnt    <= 6'd0;
      r_left   <= 1'b0;
      r_sign   <= 1'b0;
      r_nan    <= 1'b0;
      r_ovf    <= 1'b0;
      r_tdata  <= 32'd0;
      r_tuser  <= 2'b00;
      r_tvalid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_hs) begin
            r_sign <= w_sign;
            r_nan  <= w_nan;
            r_ovf  <= w_big & ~w_nan;
            r_left <= ~w_s[9];
            r_acc  <= w_special ? 32'd0 : {8'd0, 1'b1, w_frac};
            r_cnt  <= w_special ? 6'd0 : w_cnt;
            r_state <= (!w_special && w_cnt != 6'd0) ? StShift : StFix;
          end
        end
        StShift: begin
          r_acc <= r_left ? {r_acc[30:0], 1'b0} : {1'b0, r_acc[31:1]};
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_tdata  <= w_fix_data;
          r_tuser  <= w_fix_user;
          r_tvalid <= 1'b1;
          r_state  <= StOut;
        end
        StOut: begin
          if (m_axis_tready) begin
            r_tvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_fp_to_fixed_stream.sv
// Directed self-checking bench for fp_to_fixed_stream at FRAC_BITS=16.
// Expected values for rounding-sensitive vectors follow FP2FIX_ROUND_EN.
module tb_fp_to_fixed_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [1:0]  m_tuser;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FP2FIX_ROUND_EN
  localparam logic [31:0] ExpRnd = 32'h0001_0001;
  localparam logic [31:0] ExpS24 = 32'h0000_0001;
`else
  localparam logic [31:0] ExpRnd = 32'h0001_0000;
  localparam logic [31:0] ExpS24 = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  fp_to_fixed_stream #(
    .FRAC_BITS(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tuser (m_tuser)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic send(input string tag, input logic [31:0] din);
    int n = 0;
    @(negedge clk);
    s_tdata  = din;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(s_tready), 32'd1);
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  // Counts negedges after the handshake edge until tvalid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_tvalid && lat < 100);
  endtask

  task automatic run(input string tag, input logic [31:0] din, input logic [31:0] want_d,
                     input logic [1:0] want_u, input int want_lat);
    int lat;
    send(tag, din);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(want_lat));
    check({tag, "_data"}, m_tdata, want_d);
    check({tag, "_user"}, 32'(m_tuser), 32'(want_u));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    rst_n    = 1'b0;
    s_tdata  = 32'd0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_in_ready", 32'(s_tready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(s_tready), 32'd1);

    run("p2_7",   32'h402c_cccd, 32'h0002_b333, 2'b00, 8);
    run("n1_5",   32'hbfc0_0000, 32'hfffe_8000, 2'b00, 9);
    run("rnd",    32'h3f80_0040, ExpRnd,        2'b00, 9);
    run("s0",     32'h4300_0000, 32'h0080_0000, 2'b00, 2);
    run("s7",     32'h4680_0000, 32'h4000_0000, 2'b00, 9);
    run("s7neg",  32'hc6ff_ffff, 32'h8000_0080, 2'b00, 9);
    run("sm24",   32'h3700_0000, ExpS24,        2'b00, 26);
    run("tiny",   32'h3600_0000, 32'h0000_0000, 2'b00, 2);
    run("big",    32'h471c_4000, 32'h7fff_ffff, 2'b01, 2);
    run("ninf",   32'hff80_0000, 32'h8000_0000, 2'b01, 2);
    run("nan",    32'h7fc0_0000, 32'h0000_0000, 2'b10, 2);
    run("zero",   32'h0000_0000, 32'h0000_0000, 2'b00, 2);
    run("denorm", 32'h8000_0001, 32'h0000_0000, 2'b00, 2);

    // Backpressure: result must hold while downstream stalls
    m_tready = 1'b0;
    send("bp", 32'h402c_cccd);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 10; i++) begin
      check("bp_tvalid", 32'(m_tvalid), 32'd1);
      check("bp_tdata", m_tdata, 32'h0002_b333);
      check("bp_tuser", 32'(m_tuser), 32'd0);
      check("bp_in_ready", 32'(s_tready), 32'd0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    @(negedge clk);
    check("bp_release_tvalid", 32'(m_tvalid), 32'd0);
    check("bp_release_in_ready", 32'(s_tready), 32'd1);

    // Reset during SHIFT discards the word
    send("rstmid", 32'h402c_cccd);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_tvalid", 32'(m_tvalid), 32'd0);
    check("rstmid_in_ready", 32'(s_tready), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m_tvalid) seen = 1'b1;
    end
    check("rstmid_no_stale", 32'(seen), 32'd0);
    run("post_rst_zero", 32'h0000_0000, 32'h0000_0000, 2'b00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
